// File: rtl/bus_bit_gather_if.sv
// Handshake and configuration bundle for bus_bit_gather.
// The slave modport is the gather block; the master modport is whoever drives it.
interface bus_bit_gather_if #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 2
);
    logic                 cfg_we;
    logic [IDX_WIDTH-1:0] cfg_idx;
    logic [IDX_WIDTH-1:0] cfg_src;
    logic                 cfg_en;
    logic                 cfg_ready;
    logic                 cfg_err;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [WIDTH-1:0]     out_unmapped;

    modport master (
        output cfg_we, cfg_idx, cfg_src, cfg_en, in_valid, in_data, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_data, out_unmapped
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_src, cfg_en, in_valid, in_data, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_data, out_unmapped
    );
endinterface

// File: rtl/bus_bit_gather.sv
// Gathers scattered bus bits back into destination order through a programmable
// per-bit source map, behind a 2-stage valid/ready pipeline.
module bus_bit_gather #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 2
) (
    input logic             clk,
    input logic             rst,
    bus_bit_gather_if.slave bus
);
    localparam logic [IDX_WIDTH:0] LIMIT = (IDX_WIDTH + 1)'(WIDTH);

    logic [WIDTH-1:0]                map_en;
    logic [WIDTH-1:0][IDX_WIDTH-1:0] map_src;
    logic [WIDTH-1:0]                unmapped;
    logic                            vld_p1;
    logic                            vld_p2;
    logic [WIDTH-1:0]                data_p1;
    logic [WIDTH-1:0]                data_p2;
    logic                            err_q;
    logic                            adv_p1;
    logic                            in_ready_c;
    logic                            accept_p0;
    logic                            cfg_ready_c;
    logic                            cfg_ok;

    function automatic logic [WIDTH-1:0] gather(
        input logic [WIDTH-1:0]                word,
        input logic [WIDTH-1:0]                en,
        input logic [WIDTH-1:0][IDX_WIDTH-1:0] src
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) r[i] = word[src[i]];
        end
        return r;
    endfunction

    assign adv_p1      = !vld_p2 || bus.out_ready;
    assign in_ready_c  = !bus.cfg_we && (!vld_p1 || adv_p1);
    assign accept_p0   = bus.in_valid && in_ready_c;
    // Map writes are only legal with nothing in flight, so every word sees one map.
    assign cfg_ready_c = !vld_p1 && !vld_p2;
    assign cfg_ok      = bus.cfg_we && cfg_ready_c &&
                         ({1'b0, bus.cfg_idx} < LIMIT) && ({1'b0, bus.cfg_src} < LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            map_en   <= '0;
            map_src  <= '0;
            unmapped <= '1;
            err_q    <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            data_p2  <= '0;
        end else begin
            err_q <= bus.cfg_we && !cfg_ok;
            for (int i = 0; i < WIDTH; i++) begin
                if (cfg_ok && (bus.cfg_idx == IDX_WIDTH'(i))) begin
                    map_en[i]   <= bus.cfg_en;
                    map_src[i]  <= bus.cfg_src;
                    unmapped[i] <= !bus.cfg_en;
                end
            end
            // p0 -> p1: capture the scattered word
            if (accept_p0) begin
                vld_p1 <= 1'b1;
            end else if (adv_p1) begin
                vld_p1 <= 1'b0;
            end
            // p1 -> p2: gather under the current map
            if (adv_p1) begin
                vld_p2 <= vld_p1;
                if (vld_p1) data_p2 <= gather(data_p1, map_en, map_src);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0) data_p1 <= bus.in_data;
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.cfg_ready    = cfg_ready_c;
    assign bus.cfg_err      = err_q;
    assign bus.out_valid    = vld_p2;
    assign bus.out_data     = data_p2;
    assign bus.out_unmapped = unmapped;
endmodule
